spk_translator: RTL and testbench
=================================

SPK_TRANSLATOR -- requirements
Module: spk_translator

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: sample-memory address width; buffer depth is 2^ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 18: sample width, two's complement; legal range 1..31.
REQ-003 Parameter CLK_DIV, default 2: clk cycles per BCLK half-period; legal range >=1.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-006 en  in  1  playback enable, sampled every clk.
REQ-007 spk_data  in  DATA_WIDTH  sample read from the synchronous RAM at spk_addr; valid one clk after spk_addr changes.
REQ-008 BCLK  out  1  I2S bit clock to the DAC.
REQ-009 LRCLK  out  1  I2S word select; 0 = left, 1 = right.
REQ-010 DIN  out  1  I2S serial data to the DAC.
REQ-011 spk_addr  out  ADDR_WIDTH  sample-memory read address.
REQ-012 frame_start  out  1  one-clk pulse when a new sample is latched.

Function
REQ-013 The block SHALL have two states, IDLE and RUN.
REQ-014 In IDLE: BCLK=0, LRCLK=0, DIN=0, divider and bit counter held at 0, spk_addr held.
REQ-015 IDLE with en=1 SHALL, on that edge: latch spk_data into sample_reg, increment spk_addr, pulse frame_start, enter RUN.
REQ-016 In RUN, a divider SHALL count 0..CLK_DIV-1; at CLK_DIV-1 BCLK toggles and the divider returns to 0; BCLK period = 2*CLK_DIV clk.
REQ-017 A 6-bit bit counter SHALL increment (mod 64) on every falling BCLK toggle; one frame = 64 BCLK periods = 128*CLK_DIV clk.
REQ-018 LRCLK, DIN and bit counter SHALL update on the same clk edge as the falling BCLK toggle; no change on rising toggles.
REQ-019 LRCLK SHALL be 0 for bit counts 0..31 and 1 for 32..63.
REQ-020 With k = bit count mod 32: DIN = sample_reg[DATA_WIDTH-k] for 1<=k<=DATA_WIDTH, else 0 (I2S one-BCLK delay, MSB first, zero pad).
REQ-021 The same sample_reg SHALL be sent on left and right (mono).
REQ-022 Frame boundary = falling toggle with bit count 63; with en=1: latch spk_data, increment spk_addr, pulse frame_start, stay RUN.
REQ-023 Frame boundary with en=0: go IDLE, no latch, spk_addr unchanged, no frame_start; BCLK/LRCLK/DIN already 0.
REQ-024 en deasserted mid-frame SHALL NOT truncate the frame; en is only evaluated in IDLE and at frame boundaries.
REQ-025 spk_addr SHALL wrap from 2^ADDR_WIDTH-1 to 0.
REQ-026 spk_addr SHALL be stable for at least one full frame before each latch, satisfying the 1-clk RAM latency.
REQ-027 frame_start SHALL be high for exactly one clk per latch.

Reset
REQ-028 While rst=0 (asynchronous): state=IDLE, BCLK=0, LRCLK=0, DIN=0, spk_addr=0, frame_start=0, sample_reg=0, counters=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; after release, no output activity until en=1.
REQ-030 First sample transmitted after reset SHALL be from address 0.

Verification
REQ-031 Reset then en=1, RAM[0]=18'h2AAAA, CLK_DIV=2 -> frame_start at first edge, spk_addr=1, BCLK period 4 clk, left slot DIN after LRCLK fall = 0,1,0,1,... (18 bits) then 14 zeros; right slot identical.
REQ-032 en held 1 for 9 frames, RAM[i]=i -> spk_addr sequence 1..7,0,1; frame_start spacing exactly 256 clk; 9th frame carries value 0.
REQ-033 en dropped at mid-frame -> frame completes all 64 BCLK; then BCLK/LRCLK/DIN stay 0, spk_addr holds; en=1 again resumes with the next address.
REQ-034 RAM[0]=18'h3FFFF then 18'h00001 -> DIN high for slots 1..18 of both channels; next frame DIN high only at slot 18.
REQ-035 rst=0 pulse during right channel -> all outputs 0 in the same cycle without a clk edge; spk_addr=0; re-enable transmits from address 0.
REQ-036 CLK_DIV=1 -> BCLK toggles every clk, frame = 128 clk, DIN changes only when BCLK falls.

Source files
------------

// File: rtl/spk_translator.sv
// spk_translator: turns mono samples fetched from a synchronous RAM into an
// I2S stream (BCLK / LRCLK / DIN) for a DAC. The same sample is sent in the
// left and the right slot. Each slot is 32 BCLK periods long: a one-BCLK
// delay bit, then the sample MSB first, then zero padding.
//
// Ports
//   clk          system clock; all state updates on its rising edge
//   rst          asynchronous active-low reset
//   en           playback enable; looked at only in IDLE and at frame boundaries
//   spk_data     sample read from the RAM at spk_addr (one clk read latency)
//   BCLK         I2S bit clock, period 2*CLK_DIV clk
//   LRCLK        I2S word select, 0 = left, 1 = right
//   DIN          I2S serial data; changes only on falling BCLK
//   spk_addr     RAM read address; advances by one at every sample latch
//   frame_start  one-clk pulse at every sample latch
module spk_translator #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 18,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] spk_data,
    output logic                  BCLK,
    output logic                  LRCLK,
    output logic                  DIN,
    output logic [ADDR_WIDTH-1:0] spk_addr,
    output logic                  frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_reg,   state_next;
    logic [DIV_W-1:0]        div_reg,     div_next;
    logic [5:0]              bit_cnt_reg, bit_cnt_next;
    logic                    bclk_reg,    bclk_next;
    logic                    lrclk_reg,   lrclk_next;
    logic                    din_reg,     din_next;
    logic                    fs_reg,      fs_next;
    logic [ADDR_WIDTH-1:0]   addr_reg,    addr_next;
    logic [DATA_WIDTH-1:0]   sample_reg,  sample_next;

    // Sample left-aligned in a 32-bit slot. Slot position k (1..31) maps to
    // bit 32-k, so k=1 is the MSB, k>DATA_WIDTH falls in the zero padding,
    // and k=0 wraps to bit 0, which is always padding (DATA_WIDTH <= 31).
    logic [31:0] slot_word;
    logic [5:0]  bit_cnt_inc;
    logic [4:0]  slot_idx;

    assign slot_word   = {sample_reg, {(32-DATA_WIDTH){1'b0}}};
    assign bit_cnt_inc = bit_cnt_reg + 6'd1;
    assign slot_idx    = 5'd0 - bit_cnt_inc[4:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            div_reg     <= '0;
            bit_cnt_reg <= '0;
            bclk_reg    <= 1'b0;
            lrclk_reg   <= 1'b0;
            din_reg     <= 1'b0;
            fs_reg      <= 1'b0;
            addr_reg    <= '0;
            sample_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            bit_cnt_reg <= bit_cnt_next;
            bclk_reg    <= bclk_next;
            lrclk_reg   <= lrclk_next;
            din_reg     <= din_next;
            fs_reg      <= fs_next;
            addr_reg    <= addr_next;
            sample_reg  <= sample_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        bit_cnt_next = bit_cnt_reg;
        bclk_next    = bclk_reg;
        lrclk_next   = lrclk_reg;
        din_next     = din_reg;
        fs_next      = 1'b0;
        addr_next    = addr_reg;
        sample_next  = sample_reg;

        case (state_reg)
            IDLE: begin
                div_next     = '0;
                bit_cnt_next = '0;
                bclk_next    = 1'b0;
                lrclk_next   = 1'b0;
                din_next     = 1'b0;
                if (en) begin
                    sample_next = spk_data;
                    addr_next   = addr_reg + 1'b1;
                    fs_next     = 1'b1;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (div_reg == DIV_MAX) begin
                    div_next  = '0;
                    bclk_next = ~bclk_reg;
                    // Serial outputs move only with the falling BCLK edge so
                    // the DAC sees them stable around its rising-edge sample.
                    if (bclk_reg) begin
                        bit_cnt_next = bit_cnt_inc;
                        lrclk_next   = bit_cnt_inc[5];
                        din_next     = slot_word[slot_idx];
                        // Last bit of the right slot: frame boundary. The
                        // address was stable for a whole frame, so spk_data
                        // already holds the RAM word for it.
                        if (bit_cnt_reg == 6'd63) begin
                            if (en) begin
                                sample_next = spk_data;
                                addr_next   = addr_reg + 1'b1;
                                fs_next     = 1'b1;
                            end else begin
                                state_next = IDLE;
                            end
                        end
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign BCLK        = bclk_reg;
    assign LRCLK       = lrclk_reg;
    assign DIN         = din_reg;
    assign spk_addr    = addr_reg;
    assign frame_start = fs_reg;

endmodule

// File: tb/tb_spk_translator.sv
// Testbench for spk_translator: one instance with CLK_DIV=2 checked by a
// slot scoreboard, one instance with CLK_DIV=1 checked for BCLK rate, frame
// length and DIN timing.
module tb_spk_translator;

    localparam int DW = 18;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_a, en_b;
    logic [DW-1:0] data_a, data_b;
    logic          bclk_a, lrclk_a, din_a, fs_a;
    logic          bclk_b, lrclk_b, din_b, fs_b;
    logic [AW-1:0] addr_a, addr_b;

    logic [DW-1:0] ram [8];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spk_translator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .spk_data(data_a),
        .BCLK(bclk_a), .LRCLK(lrclk_a), .DIN(din_a),
        .spk_addr(addr_a), .frame_start(fs_a)
    );

    spk_translator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .spk_data(data_b),
        .BCLK(bclk_b), .LRCLK(lrclk_b), .DIN(din_b),
        .spk_addr(addr_b), .frame_start(fs_b)
    );

    // Synchronous RAM model: registered read, one clk latency.
    always @(posedge clk) begin
        data_a <= ram[addr_a];
        data_b <= ram[addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard for instance A ----------------
    logic [31:0]   sb_q[$];
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_w, exp_slot, slot_w;
    logic          last_lr, bclk_prev_a;
    int            bit_n;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb_q.delete();
                exp_addr    = '0;
                last_lr     = 1'b1;
                bit_n       = 0;
                slot_w      = '0;
                bclk_prev_a = 1'b0;
            end else begin
                if (fs_a) begin
                    exp_w = {1'b0, ram[exp_addr], {(31-DW){1'b0}}};
                    sb_q.push_back(exp_w);
                    sb_q.push_back(exp_w);
                    exp_addr = exp_addr + 1'b1;
                    $display("frame_start A: addr=%0d sample=%h", addr_a, exp_w[30:31-DW]);
                    chk("fs_addr", 32'(addr_a), 32'(exp_addr));
                end
                if (bclk_a && !bclk_prev_a) begin
                    if (lrclk_a != last_lr) begin
                        bit_n  = 0;
                        slot_w = '0;
                    end
                    slot_w  = {slot_w[30:0], din_a};
                    bit_n++;
                    last_lr = lrclk_a;
                    if (bit_n == 32) begin
                        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                        if (sb_q.size() != 0) begin
                            exp_slot = sb_q.pop_front();
                            $display("slot %s: got %h expected %h", lrclk_a ? "R" : "L", slot_w, exp_slot);
                            chk(lrclk_a ? "slot_right" : "slot_left", slot_w, exp_slot);
                        end
                        bit_n = 0;
                    end
                end
                bclk_prev_a = bclk_a;
            end
        end
    end

    // ---------------- DIN timing monitor for instance B ----------------
    int   din_viol_b = 0;
    int   din_chg_b  = 0;
    logic bclk_prev_b = 1'b0;
    logic din_prev_b  = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (din_b != din_prev_b) begin
                din_chg_b++;
                if (!(bclk_prev_b && !bclk_b)) din_viol_b++;
            end
            bclk_prev_b = bclk_b;
            din_prev_b  = din_b;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_fs(input bit use_b, input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(use_b ? fs_b : fs_a) && waited < budget);
        if (!(use_b ? fs_b : fs_a)) chk("fs_timeout", 32'(use_b ? fs_b : fs_a), 32'd1);
    endtask

    task automatic measure_bclk_period(output int period);
        logic prev;
        int   first;
        prev   = bclk_a;
        first  = -1;
        period = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bclk_a && !prev) begin
                if (first < 0) first = n;
                else begin
                    period = n - first;
                    break;
                end
            end
            prev = bclk_a;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int   waited, period, rises, fs_cnt, toggles, activity;
    logic prev;

    initial begin
        rst  = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        for (int i = 0; i < 8; i++) ram[i] = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_bclk",  32'(bclk_a),  32'd0);
        chk("rst_lrclk", 32'(lrclk_a), 32'd0);
        chk("rst_din",   32'(din_a),   32'd0);
        chk("rst_addr",  32'(addr_a),  32'd0);
        chk("rst_fs",    32'(fs_a),    32'd0);

        // Alternating pattern, first frame after reset
        ram[0] = 18'h2AAAA;
        ram[1] = 18'h15555;
        rst = 1'b1;
        @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        chk("t1_fs",   32'(fs_a),   32'd1);
        chk("t1_addr", 32'(addr_a), 32'd1);
        measure_bclk_period(period);
        $display("BCLK period A = %0d clk", period);
        chk("t1_bclk_period", 32'(period), 32'd4);
        en_a = 1'b0;
        repeat (300) @(negedge clk);

        // Nine back-to-back frames, RAM[i] = i
        for (int i = 0; i < 8; i++) ram[i] = DW'(i);
        do_reset();
        en_a = 1'b1;
        wait_fs(1'b0, 20, waited);
        for (int f = 1; f < 9; f++) begin
            wait_fs(1'b0, 400, waited);
            $display("frame %0d gap=%0d addr=%0d", f + 1, waited, addr_a);
            chk("t2_gap",  32'(waited), 32'd256);
            chk("t2_addr", 32'(addr_a), 32'((f + 1) % 8));
        end

        // Enable dropped mid-frame: frame still completes
        rises  = 0;
        fs_cnt = 0;
        prev   = bclk_a;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (i == 100) en_a = 1'b0;
            if (bclk_a && !prev) rises++;
            if (fs_a) fs_cnt++;
            prev = bclk_a;
        end
        $display("en drop: rises=%0d frame_starts=%0d", rises, fs_cnt);
        chk("t3_rises",  32'(rises),  32'd64);
        chk("t3_no_fs",  32'(fs_cnt), 32'd0);
        activity = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bclk_a || lrclk_a || din_a) activity++;
        end
        chk("t3_quiet",     32'(activity), 32'd0);
        chk("t3_addr_hold", 32'(addr_a),   32'd1);
        en_a = 1'b1;
        wait_fs(1'b0, 20, waited);
        chk("t3_resume_addr", 32'(addr_a), 32'd2);
        en_a = 1'b0;
        repeat (300) @(negedge clk);

        // All-ones then LSB-only
        ram[0] = 18'h3FFFF;
        ram[1] = 18'h00001;
        do_reset();
        en_a = 1'b1;
        wait_fs(1'b0, 20, waited);
        wait_fs(1'b0, 400, waited);
        chk("t4_gap", 32'(waited), 32'd256);
        en_a = 1'b0;
        repeat (300) @(negedge clk);

        // Asynchronous reset during the right channel
        ram[0] = 18'h12345;
        ram[1] = 18'h0F0F0;
        do_reset();
        en_a = 1'b1;
        wait_fs(1'b0, 20, waited);
        wait_fs(1'b0, 400, waited);
        waited = 0;
        while (!(lrclk_a && bclk_a) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("t5_in_right", 32'(lrclk_a && bclk_a), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("t5_bclk",  32'(bclk_a),  32'd0);
        chk("t5_lrclk", 32'(lrclk_a), 32'd0);
        chk("t5_addr",  32'(addr_a),  32'd0);
        en_a = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        activity = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bclk_a || lrclk_a || din_a || fs_a) activity++;
        end
        chk("t5_quiet", 32'(activity), 32'd0);
        en_a = 1'b1;
        wait_fs(1'b0, 20, waited);
        chk("t5_restart_addr", 32'(addr_a), 32'd1);
        en_a = 1'b0;
        repeat (300) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        // CLK_DIV = 1 instance
        ram[0] = 18'h3FFFF;
        ram[1] = 18'h2AAAA;
        en_b = 1'b1;
        wait_fs(1'b1, 20, waited);
        toggles = 0;
        prev    = bclk_b;
        waited  = 0;
        do begin
            @(negedge clk);
            waited++;
            if (bclk_b != prev) toggles++;
            prev = bclk_b;
        end while (!fs_b && waited < 300);
        $display("B frame: gap=%0d toggles=%0d", waited, toggles);
        chk("b_gap",     32'(waited),  32'd128);
        chk("b_toggles", 32'(toggles), 32'd128);
        chk("b_addr",    32'(addr_b),  32'd2);
        en_b = 1'b0;
        repeat (200) @(negedge clk);
        chk("b_din_active", 32'(din_chg_b != 0), 32'd1);
        chk("b_din_timing", 32'(din_viol_b),     32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
